// File: rtl/input_loader.sv
// input_loader: serial-to-parallel loader for the LOAD phase of the top-level FSM.
// Assembles the 28x28 binary image and the 3x3x8 conv weights from BUS_W-bit bytes.
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing XOR check byte,
// the S_CHK/S_ERR states and the sticky load_err flag).
module input_loader #(
  parameter int PIX_BITS = 784,
  parameter int WT_BITS  = 72,
  parameter int BUS_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          state,
  input  logic [BUS_W-1:0]    data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic [PIX_BITS-1:0] pixels,
  output logic [WT_BITS-1:0]  weights,
  output logic [6:0]          byte_count,
  output logic                load_done,
  output logic                load_err
);

  localparam int NPIX   = PIX_BITS / BUS_W;
  localparam int NWT    = WT_BITS / BUS_W;
  localparam int PIX_IW = $clog2(PIX_BITS);
  localparam int WT_IW  = $clog2(WT_BITS);
  localparam logic [2:0] TOP_LOAD = 3'b001;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_PIX  = 3'd0,
    S_WT   = 3'd1,
    S_CHK  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } fsm_t;

  // Running checksum step; kept as a function so the fold is defined in one place.
  function automatic logic [BUS_W-1:0] xor_fold(input logic [BUS_W-1:0] acc,
                                                input logic [BUS_W-1:0] din);
    return acc ^ din;
  endfunction

  logic [BUS_W-1:0] xor_r;
  logic             load_err_r;
`else
  typedef enum logic [2:0] {
    S_PIX  = 3'd0,
    S_WT   = 3'd1,
    S_DONE = 3'd3
  } fsm_t;
`endif

  fsm_t                fsm_r;
  logic [PIX_BITS-1:0] pixels_r;
  logic [WT_BITS-1:0]  weights_r;
  logic [6:0]          byte_count_r;
  logic                load_done_r;
  logic                fsm_open_s;
  logic                accept_s;
  logic [PIX_IW-1:0]   pix_base_s;
  logic [WT_IW-1:0]    wt_base_s;

  // Handshake: loader is open only in a receiving state while the top level is in LOAD.
  always_comb begin
    fsm_open_s = 1'b0;
    case (fsm_r)
      S_PIX:   fsm_open_s = 1'b1;
      S_WT:    fsm_open_s = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:   fsm_open_s = 1'b1;
`endif
      default: fsm_open_s = 1'b0;
    endcase
    data_ready = (state == TOP_LOAD) && fsm_open_s;
    accept_s   = data_valid && data_ready;
    pix_base_s = PIX_IW'(int'(byte_count_r) * BUS_W);
    wt_base_s  = WT_IW'(int'(byte_count_r) * BUS_W);
  end

  // Load sequencer: writes each accepted byte into its slice and walks the phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r        <= S_PIX;
      pixels_r     <= '0;
      weights_r    <= '0;
      byte_count_r <= 7'd0;
      load_done_r  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_r        <= '0;
      load_err_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      case (fsm_r)
        S_PIX: begin
          pixels_r[pix_base_s +: BUS_W] <= data_in;
`ifdef LOADER_CHECKSUM_EN
          xor_r <= xor_fold(xor_r, data_in);
`endif
          if (byte_count_r == 7'(NPIX - 1)) begin
            byte_count_r <= 7'd0;
            fsm_r        <= S_WT;
          end else begin
            byte_count_r <= byte_count_r + 7'd1;
          end
        end
        S_WT: begin
          weights_r[wt_base_s +: BUS_W] <= data_in;
`ifdef LOADER_CHECKSUM_EN
          xor_r <= xor_fold(xor_r, data_in);
`endif
          // The last weight index stays on byte_count so it reads NWT-1 afterwards.
          if (byte_count_r == 7'(NWT - 1)) begin
`ifdef LOADER_CHECKSUM_EN
            fsm_r       <= S_CHK;
`else
            fsm_r       <= S_DONE;
            load_done_r <= 1'b1;
`endif
          end else begin
            byte_count_r <= byte_count_r + 7'd1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (data_in == xor_r) begin
            fsm_r       <= S_DONE;
            load_done_r <= 1'b1;
          end else begin
            fsm_r      <= S_ERR;
            load_err_r <= 1'b1;
          end
        end
`endif
        default: fsm_r <= fsm_r;
      endcase
    end
  end

  assign pixels     = pixels_r;
  assign weights    = weights_r;
  assign byte_count = byte_count_r;
  assign load_done  = load_done_r;
`ifdef LOADER_CHECKSUM_EN
  assign load_err   = load_err_r;
`else
  assign load_err   = 1'b0;
`endif

endmodule

// File: tb/tb_input_loader.sv
// Self-checking bench for input_loader: a reference model updates on every expected
// acceptance and pushes the written slice to a scoreboard queue, drained the cycle after.
module tb_input_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   state;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         data_ready;
  logic [783:0] pixels;
  logic [71:0]  weights;
  logic [6:0]   byte_count;
  logic         load_done;
  logic         load_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         is_wt;
    int         idx;
    logic [7:0] val;
  } sb_t;
  sb_t sb_q[$];

  // Reference model: phase 0=pix 1=wt 2=chk 3=done 4=err
  int           m_phase;
  int           m_idx;
  int           acc_count;
  logic [783:0] m_pix;
  logic [71:0]  m_wt;
  logic [7:0]   m_xor;

  input_loader dut (
    .clk(clk), .rst(rst), .state(state), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .pixels(pixels), .weights(weights), .byte_count(byte_count),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [783:0] obs, input logic [783:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_idx   = 0;
    m_pix   = '0;
    m_wt    = '0;
    m_xor   = 8'h00;
    acc_count = 0;
    sb_q.delete();
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input logic [7:0] v, input logic valid);
    logic exp_ready;
    logic acc;
    sb_t  e;
    data_in    = v;
    data_valid = valid;
    #1;
    exp_ready = (state == 3'b001) && (m_phase <= 2);
    chk("data_ready", {783'd0, data_ready}, {783'd0, exp_ready});
    acc = valid && exp_ready;
    @(posedge clk);
    if (acc) begin
      acc_count++;
      case (m_phase)
        0: begin
          m_pix[m_idx*8 +: 8] = v;
          m_xor = m_xor ^ v;
          e.is_wt = 1'b0; e.idx = m_idx; e.val = v;
          sb_q.push_back(e);
          if (m_idx == 97) begin m_idx = 0; m_phase = 1; end
          else m_idx++;
        end
        1: begin
          m_wt[m_idx*8 +: 8] = v;
          m_xor = m_xor ^ v;
          e.is_wt = 1'b1; e.idx = m_idx; e.val = v;
          sb_q.push_back(e);
          if (m_idx == 8) begin
`ifdef LOADER_CHECKSUM_EN
            m_phase = 2;
`else
            m_phase = 3;
`endif
          end else m_idx++;
        end
        2: m_phase = (v == m_xor) ? 3 : 4;
        default: ;
      endcase
    end
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_wt) chk("wt_slice", {776'd0, weights[e.idx*8 +: 8]}, {776'd0, e.val});
      else         chk("pix_slice", {776'd0, pixels[e.idx*8 +: 8]}, {776'd0, e.val});
    end
    chk("byte_count", {777'd0, byte_count}, 784'(m_idx));
    chk("load_done", {783'd0, load_done}, {783'd0, (m_phase == 3)});
    chk("load_err", {783'd0, load_err}, {783'd0, (m_phase == 4)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    data_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_pixels", pixels, 784'd0);
    chk("rst_weights", {712'd0, weights}, 784'd0);
    chk("rst_byte_count", {777'd0, byte_count}, 784'd0);
    chk("rst_load_done", {783'd0, load_done}, 784'd0);
    chk("rst_load_err", {783'd0, load_err}, 784'd0);
  endtask

  task automatic load_all(input logic [7:0] pv, input logic [7:0] wv);
    for (int i = 0; i < 98; i++) cycle(pv, 1'b1);
    for (int i = 0; i < 9; i++) cycle(wv, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    cycle(m_xor, 1'b1);
`endif
  endtask

  initial begin
    logic [783:0] e_pix;
    logic [71:0]  e_wt;
    rst = 1'b1; state = 3'b000; data_in = 8'h00; data_valid = 1'b0;
    @(negedge clk);
    state = 3'b001;
    do_reset();

    // 1: back-to-back full load
    load_all(8'hA5, 8'h3C);
    e_pix = {98{8'hA5}};
    e_wt  = {9{8'h3C}};
    chk("t1_pixels", pixels, e_pix);
    chk("t1_weights", {712'd0, weights}, {712'd0, e_wt});
    chk("t1_load_done", {783'd0, load_done}, 784'd1);

    // 2: counting pattern with data_valid toggling
    do_reset();
    for (int k = 0; k < 98; k++) begin
      cycle(8'(k), 1'b1);
      cycle(8'hEE, 1'b0);
    end
    for (int j = 0; j < 9; j++) begin
      cycle(8'(j), 1'b1);
      cycle(8'hEE, 1'b0);
    end
`ifdef LOADER_CHECKSUM_EN
    cycle(m_xor, 1'b1);
    chk("t2_acc_count", 784'(acc_count), 784'd108);
`else
    chk("t2_acc_count", 784'(acc_count), 784'd107);
`endif
    for (int k = 0; k < 98; k++) e_pix[k*8 +: 8] = 8'(k);
    for (int j = 0; j < 9; j++) e_wt[j*8 +: 8] = 8'(j);
    chk("t2_pixels", pixels, e_pix);
    chk("t2_weights", {712'd0, weights}, {712'd0, e_wt});

    // 3: pause after 50 pixel bytes
    do_reset();
    for (int k = 0; k < 50; k++) cycle(8'h11, 1'b1);
    state = 3'b000;
    for (int i = 0; i < 20; i++) cycle(8'h77, 1'b1);
    chk("t3_hold_count", {777'd0, byte_count}, 784'd50);
    state = 3'b001;
    cycle(8'h5A, 1'b1);
    chk("t3_resume_slice", {776'd0, pixels[407:400]}, {776'd0, 8'h5A});
    chk("t3_prev_slice", {776'd0, pixels[399:392]}, {776'd0, 8'h11});
    for (int k = 51; k < 60; k++) cycle(8'h22, 1'b1);

    // 4: reset mid-load, then reload all-ones
    do_reset();
    load_all(8'hFF, 8'hFF);
    e_pix = '1;
    chk("t4_pixels", pixels, e_pix);
    chk("t4_weights", {712'd0, weights}, {712'd0, 72'hFF_FFFF_FFFF_FFFF_FFFF});

    // 5: traffic after load_done is ignored
    for (int i = 0; i < 10; i++) cycle(8'h00, 1'b1);
    chk("t5_pixels", pixels, e_pix);
    chk("t5_weights", {712'd0, weights}, {712'd0, m_wt});
    chk("t5_load_done", {783'd0, load_done}, 784'd1);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum pass then fail
    do_reset();
    for (int i = 0; i < 107; i++) cycle(8'h01, 1'b1);
    chk("t6_xor_model", {776'd0, m_xor}, {776'd0, 8'h01});
    cycle(8'h01, 1'b1);
    chk("t6_pass_done", {783'd0, load_done}, 784'd1);
    do_reset();
    for (int i = 0; i < 107; i++) cycle(8'h01, 1'b1);
    cycle(8'h00, 1'b1);
    for (int i = 0; i < 50; i++) cycle(8'h01, 1'b1);
    chk("t6_err", {783'd0, load_err}, 784'd1);
    chk("t6_err_done", {783'd0, load_done}, 784'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
